// File: rtl/ex_stage_pkg.sv
// Shared EX-stage definitions: bus widths, operation/type encodings and ALU helpers.
package ex_stage_pkg;

    localparam int DATA_BUS    = 32;
    localparam int REG_BUS     = 5;
    localparam int RTLOP_BUS   = 4;
    localparam int RTLTYPE_BUS = 2;

    localparam logic [RTLOP_BUS-1:0] RTLOP_ADD  = 4'b0000;
    localparam logic [RTLOP_BUS-1:0] RTLOP_SLL  = 4'b0001;
    localparam logic [RTLOP_BUS-1:0] RTLOP_SLT  = 4'b0010;
    localparam logic [RTLOP_BUS-1:0] RTLOP_SLTU = 4'b0011;
    localparam logic [RTLOP_BUS-1:0] RTLOP_XOR  = 4'b0100;
    localparam logic [RTLOP_BUS-1:0] RTLOP_SHR  = 4'b0101;
    localparam logic [RTLOP_BUS-1:0] RTLOP_OR   = 4'b0110;
    localparam logic [RTLOP_BUS-1:0] RTLOP_AND  = 4'b0111;
    localparam logic [RTLOP_BUS-1:0] RTLOP_SAR  = 4'b1101;

    localparam logic [RTLTYPE_BUS-1:0] RTLTYPE_CALC = 2'b01;
    localparam logic [REG_BUS-1:0]     REG_X0       = 5'd0;

    typedef enum logic {ST_IDLE, ST_SHIFT} ex_state_t;
    typedef enum logic [1:0] {SH_LEFT, SH_RIGHT_LOGIC, SH_RIGHT_ARITH} shift_kind_t;

    function automatic logic op_defined(input logic [RTLOP_BUS-1:0] op);
        case (op)
            RTLOP_ADD, RTLOP_SLL, RTLOP_SLT, RTLOP_SLTU, RTLOP_XOR,
            RTLOP_SHR, RTLOP_OR, RTLOP_AND, RTLOP_SAR: op_defined = 1'b1;
            default:                                   op_defined = 1'b0;
        endcase
    endfunction

    function automatic logic op_is_shift(input logic [RTLOP_BUS-1:0] op);
        op_is_shift = (op == RTLOP_SLL) || (op == RTLOP_SHR) || (op == RTLOP_SAR);
    endfunction

    function automatic shift_kind_t shift_kind(input logic [RTLOP_BUS-1:0] op);
        case (op)
            RTLOP_SHR: shift_kind = SH_RIGHT_LOGIC;
            RTLOP_SAR: shift_kind = SH_RIGHT_ARITH;
            default:   shift_kind = SH_LEFT;
        endcase
    endfunction

    // Single-cycle result; shifts only reach here with a zero shift amount, so they pass data1 through.
    function automatic logic [DATA_BUS-1:0] alu_calc(input logic [RTLOP_BUS-1:0] op,
                                                     input logic [DATA_BUS-1:0] a,
                                                     input logic [DATA_BUS-1:0] b);
        case (op)
            RTLOP_ADD:  alu_calc = a + b;
            RTLOP_SLT:  alu_calc = {31'd0, ($signed(a) < $signed(b))};
            RTLOP_SLTU: alu_calc = {31'd0, (a < b)};
            RTLOP_XOR:  alu_calc = a ^ b;
            RTLOP_OR:   alu_calc = a | b;
            RTLOP_AND:  alu_calc = a & b;
            default:    alu_calc = a;
        endcase
    endfunction

endpackage

// File: rtl/ex_shifter.sv
// Iterative one-bit-per-cycle shifter: holds the accumulator, remaining count and fill mode.
module ex_shifter
    import ex_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                load,
    input  logic [1:0]          kind,
    input  logic [DATA_BUS-1:0] data,
    input  logic [4:0]          shamt,
    output logic                done,
    output logic [DATA_BUS-1:0] result
);

    logic [DATA_BUS-1:0] acc;
    logic [4:0]          cnt;
    logic [1:0]          kind_q;
    logic [DATA_BUS-1:0] shifted;

    always_comb begin
        shifted = acc;
        case (kind_q)
            SH_LEFT:        shifted = {acc[DATA_BUS-2:0], 1'b0};
            SH_RIGHT_LOGIC: shifted = {1'b0, acc[DATA_BUS-1:1]};
            SH_RIGHT_ARITH: shifted = {acc[DATA_BUS-1], acc[DATA_BUS-1:1]};
            default:        shifted = acc;
        endcase
    end

    // done marks the last step: the owner captures result on this same edge.
    assign done   = (cnt == 5'd1);
    assign result = shifted;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= '0;
            cnt    <= '0;
            kind_q <= SH_LEFT;
        end else if (flush) begin
            acc <= '0;
            cnt <= '0;
        end else if (load) begin
            acc    <= data;
            cnt    <= shamt;
            kind_q <= kind;
        end else if (cnt != 5'd0) begin
            acc <= shifted;
            cnt <= cnt - 5'd1;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU ops plus multi-cycle shifts, with stall back to ID and flush support.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   valid_i,
    input  logic [RTLOP_BUS-1:0]   rtl_op,
    input  logic [RTLTYPE_BUS-1:0] rtl_type,
    input  logic [DATA_BUS-1:0]    pc_i,
    input  logic [DATA_BUS-1:0]    data1_i,
    input  logic [DATA_BUS-1:0]    data2_i,
    input  logic [REG_BUS-1:0]     gprs_waddr_i,
    input  logic                   error_i,
    output logic                   stall_o,
    output logic                   valid_o,
    output logic [DATA_BUS-1:0]    pc_o,
    output logic                   gprs_wen,
    output logic [REG_BUS-1:0]     gprs_waddr,
    output logic [DATA_BUS-1:0]    gprs_wdata,
    output logic                   error_o
);

    ex_state_t           state;
    logic [REG_BUS-1:0]  sh_waddr;
    logic [DATA_BUS-1:0] sh_pc;
    logic [4:0]          shamt;
    logic                good;
    logic                accept;
    logic                start_shift;
    logic                sh_done;
    logic [DATA_BUS-1:0] sh_result;
    logic [1:0]          sh_kind;

    assign shamt       = data2_i[4:0];
    assign good        = (rtl_type == RTLTYPE_CALC) && op_defined(rtl_op) && !error_i;
    assign accept      = (state == ST_IDLE) && valid_i && !flush;
    assign start_shift = accept && good && op_is_shift(rtl_op) && (shamt != 5'd0);
    assign sh_kind     = shift_kind(rtl_op);
    assign stall_o     = (state == ST_SHIFT);

    ex_shifter u_shifter (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .load   (start_shift),
        .kind   (sh_kind),
        .data   (data1_i),
        .shamt  (shamt),
        .done   (sh_done),
        .result (sh_result)
    );

    // Retire strobes default low every cycle; result fields only change when something retires.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            valid_o    <= 1'b0;
            gprs_wen   <= 1'b0;
            error_o    <= 1'b0;
            gprs_waddr <= '0;
            gprs_wdata <= '0;
            pc_o       <= '0;
            sh_waddr   <= '0;
            sh_pc      <= '0;
        end else begin
            valid_o  <= 1'b0;
            gprs_wen <= 1'b0;
            error_o  <= 1'b0;
            if (flush) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            if (!good) begin
                                valid_o    <= 1'b1;
                                error_o    <= 1'b1;
                                gprs_waddr <= gprs_waddr_i;
                                pc_o       <= pc_i;
                            end else if (start_shift) begin
                                state    <= ST_SHIFT;
                                sh_waddr <= gprs_waddr_i;
                                sh_pc    <= pc_i;
                            end else begin
                                valid_o    <= 1'b1;
                                gprs_wen   <= (gprs_waddr_i != REG_X0);
                                gprs_waddr <= gprs_waddr_i;
                                gprs_wdata <= alu_calc(rtl_op, data1_i, data2_i);
                                pc_o       <= pc_i;
                            end
                        end
                    end
                    ST_SHIFT: begin
                        if (sh_done) begin
                            state      <= ST_IDLE;
                            valid_o    <= 1'b1;
                            gprs_wen   <= (sh_waddr != REG_X0);
                            gprs_waddr <= sh_waddr;
                            gprs_wdata <= sh_result;
                            pc_o       <= sh_pc;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: stimulus pushes expected retirements, a monitor pops and compares them.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, flush, valid_i, error_i;
    logic [3:0]  rtl_op;
    logic [1:0]  rtl_type;
    logic [31:0] pc_i, data1_i, data2_i;
    logic [4:0]  gprs_waddr_i;
    logic        stall_o, valid_o, gprs_wen, error_o;
    logic [31:0] pc_o, gprs_wdata;
    logic [4:0]  gprs_waddr;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        wen;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    int   st;

    ex_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .valid_i      (valid_i),
        .rtl_op       (rtl_op),
        .rtl_type     (rtl_type),
        .pc_i         (pc_i),
        .data1_i      (data1_i),
        .data2_i      (data2_i),
        .gprs_waddr_i (gprs_waddr_i),
        .error_i      (error_i),
        .stall_o      (stall_o),
        .valid_o      (valid_o),
        .pc_o         (pc_o),
        .gprs_wen     (gprs_wen),
        .gprs_waddr   (gprs_waddr),
        .gprs_wdata   (gprs_wdata),
        .error_o      (error_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Holds the instruction on the ID slot until accepted; lat is edges after acceptance until valid_o.
    task automatic applyStimulus(input logic [3:0] op, input logic [1:0] typ, input logic [31:0] pc,
                                 input logic [31:0] d1, input logic [31:0] d2, input logic [4:0] wa,
                                 input logic err, input logic expect_ret, input logic exp_wen,
                                 input logic exp_err, input logic [31:0] exp_wdata, input int lat,
                                 output int stalls);
        logic was, accepted;
        exp_t e;
        rtl_op = op; rtl_type = typ; pc_i = pc; data1_i = d1; data2_i = d2;
        gprs_waddr_i = wa; error_i = err; valid_i = 1'b1;
        stalls = 0; accepted = 1'b0;
        for (int n = 0; n < 100; n++) begin
            was = stall_o;
            @(posedge clk); #1;
            if (!was) begin accepted = 1'b1; break; end
            stalls++;
        end
        valid_i = 1'b0; error_i = 1'b0;
        if (!accepted) begin
            checks++; errors++;
            $display("[TB] FAIL accept_timeout: got stalled, expected accepted");
        end else if (expect_ret) begin
            e.pc = pc; e.waddr = wa; e.wdata = exp_wdata; e.wen = exp_wen; e.err = exp_err;
            e.cyc = cycle + lat;
            sb.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("[TB] FAIL unexpected_retire: got valid_o=1 pc=0x%08h, expected none", pc_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("ret_cycle", cycle, e.cyc);
                checkOutput("ret_pc", pc_o, e.pc);
                checkOutput("ret_waddr", {27'd0, gprs_waddr}, {27'd0, e.waddr});
                checkOutput("ret_wen", {31'd0, gprs_wen}, {31'd0, e.wen});
                checkOutput("ret_err", {31'd0, error_o}, {31'd0, e.err});
                if (e.wen) checkOutput("ret_wdata", gprs_wdata, e.wdata);
            end
        end
    end

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
        checkOutput({tag, "_wen"}, {31'd0, gprs_wen}, 32'd0);
        checkOutput({tag, "_err"}, {31'd0, error_o}, 32'd0);
        checkOutput({tag, "_stall"}, {31'd0, stall_o}, 32'd0);
        checkOutput({tag, "_waddr"}, {27'd0, gprs_waddr}, 32'd0);
        checkOutput({tag, "_wdata"}, gprs_wdata, 32'd0);
        checkOutput({tag, "_pc"}, pc_o, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; valid_i = 1'b0; error_i = 1'b0;
        rtl_op = RTLOP_ADD; rtl_type = RTLTYPE_CALC; pc_i = '0; data1_i = '0; data2_i = '0;
        gprs_waddr_i = '0;
        repeat (2) @(posedge clk);
        #1;
        checkIdleZero("reset");
        rst_n = 1'b1;

        applyStimulus(RTLOP_ADD, RTLTYPE_CALC, 32'h100, 32'hFFFF_FFFF, 32'd2, 5'd5, 1'b0,
                      1'b1, 1'b1, 1'b0, 32'h0000_0001, 0, st);
        checkOutput("add_stall_o", {31'd0, stall_o}, 32'd0);
        checkOutput("add_stalls", st, 0);

        applyStimulus(RTLOP_SAR, RTLTYPE_CALC, 32'h104, 32'h8000_0000, 32'd4, 5'd6, 1'b0,
                      1'b1, 1'b1, 1'b0, 32'hF800_0000, 4, st);
        checkOutput("sar_stall_o", {31'd0, stall_o}, 32'd1);
        applyStimulus(RTLOP_XOR, RTLTYPE_CALC, 32'h108, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd7, 1'b0,
                      1'b1, 1'b1, 1'b0, 32'hF00F_F00F, 0, st);
        checkOutput("sar_held_stalls", st, 4);

        applyStimulus(RTLOP_SLL, RTLTYPE_CALC, 32'h10C, 32'h0000_1234, 32'h0000_0020, 5'd8, 1'b0,
                      1'b1, 1'b1, 1'b0, 32'h0000_1234, 0, st);
        checkOutput("sll0_stall_o", {31'd0, stall_o}, 32'd0);

        applyStimulus(RTLOP_SHR, RTLTYPE_CALC, 32'h110, 32'h0000_00F0, 32'hFFFF_FFE4, 5'd9, 1'b0,
                      1'b1, 1'b1, 1'b0, 32'h0000_000F, 4, st);

        // Flush on the third SHIFT cycle must discard the shift entirely.
        applyStimulus(RTLOP_SHR, RTLTYPE_CALC, 32'h114, 32'h0000_00F0, 32'd8, 5'd10, 1'b0,
                      1'b0, 1'b0, 1'b0, 32'd0, 0, st);
        repeat (2) begin @(posedge clk); #1; end
        checkOutput("flush_pre_stall", {31'd0, stall_o}, 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checkOutput("flush_stall", {31'd0, stall_o}, 32'd0);
        checkOutput("flush_valid", {31'd0, valid_o}, 32'd0);
        rtl_op = RTLOP_ADD; rtl_type = RTLTYPE_CALC; data1_i = 32'd7; data2_i = 32'd7;
        gprs_waddr_i = 5'd3; pc_i = 32'h118; valid_i = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0; flush = 1'b0;
        checkOutput("flush_drop_valid", {31'd0, valid_o}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        applyStimulus(RTLOP_ADD, RTLTYPE_CALC, 32'h11C, 32'd1, 32'd1, 5'd11, 1'b0,
                      1'b1, 1'b1, 1'b0, 32'd2, 0, st);

        applyStimulus(RTLOP_ADD, 2'b10, 32'h120, 32'd3, 32'd4, 5'd12, 1'b0,
                      1'b1, 1'b0, 1'b1, 32'd0, 0, st);
        applyStimulus(4'b1000, RTLTYPE_CALC, 32'h124, 32'd3, 32'd4, 5'd12, 1'b0,
                      1'b1, 1'b0, 1'b1, 32'd0, 0, st);
        applyStimulus(RTLOP_ADD, RTLTYPE_CALC, 32'h128, 32'd3, 32'd4, 5'd12, 1'b1,
                      1'b1, 1'b0, 1'b1, 32'd0, 0, st);
        applyStimulus(RTLOP_SAR, 2'b00, 32'h12C, 32'h8000_0000, 32'd5, 5'd12, 1'b0,
                      1'b1, 1'b0, 1'b1, 32'd0, 0, st);
        checkOutput("err_shift_stall_o", {31'd0, stall_o}, 32'd0);
        applyStimulus(RTLOP_SLT, RTLTYPE_CALC, 32'h130, 32'hFFFF_FFFF, 32'd1, 5'd13, 1'b0,
                      1'b1, 1'b1, 1'b0, 32'd1, 0, st);
        applyStimulus(RTLOP_SLTU, RTLTYPE_CALC, 32'h134, 32'd1, 32'hFFFF_FFFF, 5'd0, 1'b0,
                      1'b1, 1'b0, 1'b0, 32'd1, 0, st);

        // Reset in the middle of a 31-step shift: nothing may retire afterwards.
        applyStimulus(RTLOP_SLL, RTLTYPE_CALC, 32'h140, 32'd1, 32'd31, 5'd14, 1'b0,
                      1'b0, 1'b0, 1'b0, 32'd0, 0, st);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        flush = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        flush = 1'b0;
        checkIdleZero("midshift_reset");
        repeat (40) @(posedge clk);
        #1;
        checkOutput("post_reset_stall", {31'd0, stall_o}, 32'd0);
        checkOutput("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have these ports, clock and reset first:
- clk  in  1  sole clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- flush  in  1  discard the in-flight operation.
- valid_i  in  1  ID output slot holds an instruction.
- rtl_op  in  RTLOP_BUS (4)  operation code.
- rtl_type  in  RTLTYPE_BUS (2)  operation class.
- pc_i  in  DATA_BUS (32)  instruction PC.
- data1_i  in  DATA_BUS  first operand.
- data2_i  in  DATA_BUS  second operand / immediate.
- gprs_waddr_i  in  REG_BUS (5)  destination register.
- error_i  in  1  decode error flag from ID.
- stall_o  out  1  ID SHALL hold its output registers while high.
- valid_o  out  1  result slot valid, one-cycle pulse per retired instruction.
- pc_o  out  DATA_BUS  PC of the retiring instruction.
- gprs_wen  out  1  register-file write enable.
- gprs_waddr  out  REG_BUS  write address.
- gprs_wdata  out  DATA_BUS  write data.
- error_o  out  1  instruction retired with an error.

Function
REQ-002 SHALL accept an instruction only in IDLE with valid_i=1 and flush=0.
REQ-003 SHALL decode rtl_op as follows: ADD=0000, SLL=0001, SLT=0010, SLTU=0011, XOR=0100, SHR=0101, OR=0110, AND=0111, SAR=1101.
- ADD wraps mod 2^32.
- SLT is a signed compare and SLTU an unsigned compare, both giving 0 or 1.
REQ-004 Non-shift ops and shifts with shamt=0 SHALL retire one edge after acceptance (valid_o=1 the next cycle).
REQ-005 Shift amount SHALL be data2_i[4:0], with data2_i[31:5] ignored; the shifted operand is data1_i.
REQ-006 A shift with shamt>0 SHALL run as follows:
- Load accumulator = data1_i and counter = shamt, then enter SHIFT.
- Shift one bit per cycle: SLL fills with 0, SHR fills with 0, SAR fills with the sign bit.
- Decrement the counter each cycle.
- On the edge where counter=1, register the result, pulse valid_o and return to IDLE.
- Latency from acceptance to valid_o is shamt+1 edges.
REQ-007 stall_o SHALL equal (state==SHIFT) combinationally, held through the final SHIFT cycle; valid_i SHALL be ignored while in SHIFT.
REQ-008 FSM states are IDLE and SHIFT; the only transitions are IDLE->SHIFT (REQ-006), SHIFT->IDLE (counter=1, flush, or reset) and self-loops.
REQ-009 An accepted instruction with rtl_type!=RTLTYPE_CALC, an undefined rtl_op, or error_i=1 SHALL retire in one edge with error_o=1 and gprs_wen=0, and SHALL never enter SHIFT.
REQ-010 gprs_wen SHALL be 0 when gprs_waddr_i=REG_X0, while valid_o still pulses.
REQ-011 valid_o, gprs_wen and error_o SHALL be 0 in any cycle that does not retire an instruction; gprs_waddr, gprs_wdata and pc_o hold their last values.
REQ-012 flush SHALL take priority over acceptance and completion: the next edge forces IDLE and valid_o=gprs_wen=error_o=0, and any partial shift result is lost.
REQ-013 valid_i=1 in IDLE during flush SHALL be dropped and not retired later.

Reset
REQ-014 When rst_n=0 at a rising edge, the block SHALL enter IDLE and clear valid_o, gprs_wen, error_o, stall_o, counter and accumulator.
- gprs_waddr, gprs_wdata and pc_o reset to 0.
REQ-015 Reset mid-SHIFT SHALL abort the shift with no retirement, and SHALL take priority over flush.

Structure
REQ-016 The RTLOP_*, RTLTYPE_*, REG_X0 and DATA/REG/RTLOP/RTLTYPE bus-width macros SHALL come from the shared common.v; the block SHALL define none locally.
REQ-017 The iterative shifter (accumulator, counter, fill logic, done flag) SHALL be one sub-module, ex_shifter, instantiated by ex_stage, which owns the FSM and result register.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- ADD: data1=0xFFFFFFFF, data2=2, waddr=5 -> next cycle valid_o=1, wen=1, waddr=5, wdata=0x00000001, stall_o never high.
- SAR: data1=0x80000000, data2=0x00000004 -> stall_o high 4 cycles, valid_o at edge 5, wdata=0xF8000000, next valid_i held and retired afterwards.
- SLL with shamt=0: data1=0x1234 -> one-cycle retire, wdata=0x1234, no stall.
- Flush mid-shift: SHR of 0xF0 by 8, flush on the 3rd SHIFT cycle -> no valid_o, IDLE next cycle, stall_o=0, then ADD 1+1 retires wdata=2.
- Error and x0: rtl_type!=CALC -> valid_o=1, error_o=1, wen=0; SLTU 1<0xFFFFFFFF to x0 -> valid_o=1, wen=0.
- Reset: rst_n=0 during a shift of 31 -> IDLE, all outputs 0 next edge, no later retirement.
